// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - receive-side TDM demultiplexer with frame lock and good-frame counter
module tdm_demux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 1,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        din,
    input  logic                     din_valid,
    input  logic                     sync,
    output logic [NUM_CH*DATA_W-1:0] dout,
    output logic                     frame_valid,
    output logic                     frame_err,
    output logic                     locked,
    output logic [CNT_W-1:0]         frame_cnt
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    // Only slots 0..NUM_CH-2 are buffered; the last slot goes straight from din to dout.
    logic [NUM_CH-2:0][DATA_W-1:0]   shadow_q, shadow_d;
    logic [NUM_CH*DATA_W-1:0]        dout_d;
    logic                            frame_valid_d;
    logic                            frame_err_d;
    logic                            locked_d;
    logic [CNT_W-1:0]                frame_cnt_d;

    // Register all state and outputs; reset discards any partial frame without pulsing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            idx_q       <= '0;
            shadow_q    <= '0;
            dout        <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            locked      <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            dout        <= dout_d;
            frame_valid <= frame_valid_d;
            frame_err   <= frame_err_d;
            locked      <= locked_d;
            frame_cnt   <= frame_cnt_d;
        end
    end

    // Framing decisions: slot steering, error detection and atomic frame publication.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        dout_d        = dout;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        locked_d      = locked;
        frame_cnt_d   = frame_cnt;

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    // Samples before the first sync carry no framing information; drop quietly.
                    if (sync) begin
                        shadow_d[0] = din;
                        idx_d       = IDX_W'(1);
                        state_d     = RUN;
                    end
                end

                RUN: begin
                    if (idx_q == '0) begin
                        if (sync) begin
                            shadow_d[0] = din;
                            idx_d       = IDX_W'(1);
                        end else begin
                            // Expected a frame boundary but none arrived: lose lock and re-hunt.
                            frame_err_d = 1'b1;
                            locked_d    = 1'b0;
                            idx_d       = '0;
                            state_d     = HUNT;
                        end
                    end else if (sync) begin
                        // Early sync: abandon the partial frame and treat this sample as slot 0.
                        frame_err_d = 1'b1;
                        locked_d    = 1'b0;
                        shadow_d[0] = din;
                        idx_d       = IDX_W'(1);
                    end else if (idx_q == LAST_IDX) begin
                        // Final slot: publish the whole frame in one edge.
                        dout_d        = {din, shadow_q};
                        frame_valid_d = 1'b1;
                        locked_d      = 1'b1;
                        frame_cnt_d   = frame_cnt + CNT_W'(1);
                        idx_d         = '0;
                    end else begin
                        for (int k = 1; k < NUM_CH - 1; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                shadow_d[k] = din;
                            end
                        end
                        idx_d = idx_q + IDX_W'(1);
                    end
                end

                default: begin
                    state_d = HUNT;
                    idx_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - directed scoreboard bench for tdm_demux
module tb_tdm_demux;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic                     clk;
    logic                     rst;
    logic [DATA_W-1:0]        din;
    logic                     din_valid;
    logic                     sync;
    logic [NUM_CH*DATA_W-1:0] dout;
    logic                     frame_valid;
    logic                     frame_err;
    logic                     locked;
    logic [CNT_W-1:0]         frame_cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb_q[$];
    logic [31:0] exp_dout;
    logic        exp_locked;
    logic [7:0]  exp_cnt;

    tdm_demux #(
        .NUM_CH(NUM_CH),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .dout       (dout),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .locked     (locked),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input logic exp_fv, input logic exp_fe);
        chk("frame_valid", {31'd0, frame_valid}, {31'd0, exp_fv});
        chk("frame_err", {31'd0, frame_err}, {31'd0, exp_fe});
        chk("locked", {31'd0, locked}, {31'd0, exp_locked});
        chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});
        chk("dout", dout, exp_dout);
    endtask

    // One valid sample; exp_done marks the sample that should complete a frame.
    task automatic drive(input logic [7:0] d, input logic s, input logic exp_fe,
                         input logic exp_done, input logic [31:0] frame);
        logic [31:0] got;
        @(negedge clk);
        din       = d;
        sync      = s;
        din_valid = 1'b1;
        if (exp_done) sb_q.push_back(frame);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 8'($urandom);
        sync      = 1'($urandom);
        if (exp_fe) exp_locked = 1'b0;
        if (frame_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_frame", dout, 32'hxxxx_xxxx);
            end else begin
                got = sb_q.pop_front();
                chk("sb_frame", dout, got);
                exp_dout   = got;
                exp_locked = 1'b1;
                exp_cnt    = exp_cnt + 8'd1;
            end
        end
        check_state(exp_done, exp_fe);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din_valid = 1'b0;
            din       = 8'($urandom);
            sync      = 1'($urandom);
            @(posedge clk);
            #1;
            check_state(1'b0, 1'b0);
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic first_err, input int max_gap);
        drive(b0, 1'b1, first_err, 1'b0, 32'd0);
        idle($urandom_range(max_gap, 0));
        drive(b1, 1'b0, 1'b0, 1'b0, 32'd0);
        idle($urandom_range(max_gap, 0));
        drive(b2, 1'b0, 1'b0, 1'b0, 32'd0);
        idle($urandom_range(max_gap, 0));
        drive(b3, 1'b0, 1'b0, 1'b1, {b3, b2, b1, b0});
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst       = 1'b1;
            din       = 8'($urandom);
            din_valid = 1'($urandom);
            sync      = 1'($urandom);
            @(posedge clk);
            #1;
            exp_dout   = 32'd0;
            exp_locked = 1'b0;
            exp_cnt    = 8'd0;
            sb_q.delete();
            check_state(1'b0, 1'b0);
        end
        @(negedge clk);
        rst       = 1'b0;
        din_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] r0, r1, r2, r3;
        rst        = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        sync       = 1'b0;
        exp_dout   = 32'd0;
        exp_locked = 1'b0;
        exp_cnt    = 8'd0;

        // Reset with random inputs
        do_reset(3);

        // Good frame, back-to-back valids, then confirm single-cycle pulse
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 0);
        chk("first_frame_dout", dout, 32'h4433_2211);
        chk("first_frame_cnt", {24'd0, frame_cnt}, 32'd1);
        idle(1);

        // Gapped frame
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 3);
        chk("gapped_cnt", {24'd0, frame_cnt}, 32'd2);
        idle(2);

        // Early sync abandons A-frame, B-frame completes
        drive(8'hA0, 1'b1, 1'b0, 1'b0, 32'd0);
        drive(8'hA1, 1'b0, 1'b0, 1'b0, 32'd0);
        send_frame(8'hB0, 8'hB1, 8'hB2, 8'hB3, 1'b1, 1);
        chk("early_sync_dout", dout, 32'hB3B2_B1B0);
        idle(1);

        // Missing sync: one error, then silent drops in HUNT, then recovery
        drive(8'h55, 1'b0, 1'b1, 1'b0, 32'd0);
        drive(8'h66, 1'b0, 1'b0, 1'b0, 32'd0);
        idle(2);
        drive(8'h77, 1'b0, 1'b0, 1'b0, 32'd0);
        send_frame(8'hC0, 8'hC1, 8'hC2, 8'hC3, 1'b0, 2);
        chk("recover_cnt", {24'd0, frame_cnt}, 32'd4);

        // Counter wrap: 256 more good frames returns the count to its start value
        for (int f = 0; f < 256; f++) begin
            r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
            send_frame(r0, r1, r2, r3, 1'b0, 0);
            if (exp_cnt == 8'd0) chk("wrap_locked", {31'd0, locked}, 32'd1);
        end
        chk("wrap_cnt", {24'd0, frame_cnt}, 32'd4);

        // Mid-frame reset discards partial frame
        drive(8'hD0, 1'b1, 1'b0, 1'b0, 32'd0);
        drive(8'hD1, 1'b0, 1'b0, 1'b0, 32'd0);
        drive(8'hD2, 1'b0, 1'b0, 1'b0, 32'd0);
        do_reset(1);
        idle(1);
        drive(8'hEE, 1'b0, 1'b0, 1'b0, 32'd0);
        send_frame(8'hE0, 8'hE1, 8'hE2, 8'hE3, 1'b0, 1);
        chk("post_reset_cnt", {24'd0, frame_cnt}, 32'd1);
        chk("post_reset_dout", dout, 32'hE3E2_E1E0);
        idle(2);

        chk("sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
